// File: rtl/muldiv_iter.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with {hi,lo} result pair for the HI/LO path.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   input  logic             annul_i,
   output logic             busy_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_by_zero_o
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               state;
   logic                 is_div_r;
   logic                 neg_q_r;
   logic                 neg_r_r;
   logic [2*WIDTH-1:0]   a_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [WIDTH-1:0]     b_r;
   logic [CW-1:0]        cnt;

   logic                 sgn_op;
   logic [WIDTH-1:0]     a_abs;
   logic [WIDTH-1:0]     b_abs;
   logic [2*WIDTH-1:0]   mul_acc_nx;
   logic [2*WIDTH-1:0]   mul_a_nx;
   logic [WIDTH-1:0]     mul_b_nx;
   logic [2*WIDTH-1:0]   div_a_nx;
   logic [WIDTH:0]       part;
   logic [WIDTH-1:0]     diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;
   logic                 calc_last;
   logic                 accept_short;

   always_comb begin
      sgn_op = ~op_i[0];
      a_abs  = (sgn_op && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
      b_abs  = (sgn_op && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
   end

   // One iteration of each datapath; FIX reuses it so the last iteration and the
   // sign fix share a cycle, giving WIDTH iterations over WIDTH busy cycles.
   always_comb begin
      mul_acc_nx = b_r[0] ? acc_r + a_r : acc_r;
      mul_a_nx   = {a_r[2*WIDTH-2:0], 1'b0};
      mul_b_nx   = {1'b0, b_r[WIDTH-1:1]};
      part       = a_r[2*WIDTH-1:WIDTH-1];
      diff       = part[WIDTH-1:0] - b_r;
      if (part >= {1'b0, b_r})
         div_a_nx = {diff, a_r[WIDTH-2:0], 1'b1};
      else
         div_a_nx = {a_r[2*WIDTH-2:0], 1'b0};
   end

   always_comb begin
      prod = neg_q_r ? -mul_acc_nx : mul_acc_nx;
      quo  = neg_q_r ? -div_a_nx[WIDTH-1:0] : div_a_nx[WIDTH-1:0];
      rem  = neg_r_r ? -div_a_nx[2*WIDTH-1:WIDTH] : div_a_nx[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      calc_last    = (cnt == CW'(1));
      accept_short = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      if (!is_div_r && (mul_b_nx[WIDTH-1:1] == '0))
         calc_last = 1'b1;
      accept_short = !op_i[1] && (b_abs[WIDTH-1:1] == '0);
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         busy_o        <= 1'b0;
         ready_o       <= 1'b0;
         hi_o          <= '0;
         lo_o          <= '0;
         div_by_zero_o <= 1'b0;
         is_div_r      <= 1'b0;
         neg_q_r       <= 1'b0;
         neg_r_r       <= 1'b0;
         a_r           <= '0;
         acc_r         <= '0;
         b_r           <= '0;
         cnt           <= '0;
      end else begin
         ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i && !annul_i) begin
                  div_by_zero_o <= 1'b0;
                  is_div_r      <= op_i[1];
                  neg_q_r       <= sgn_op & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                  neg_r_r       <= sgn_op & src_a_i[WIDTH-1];
                  a_r           <= {{WIDTH{1'b0}}, a_abs};
                  acc_r         <= '0;
                  b_r           <= b_abs;
                  cnt           <= CW'(WIDTH - 1);
                  if (op_i[1] && (src_b_i == '0)) begin
                     state         <= DONE;
                     ready_o       <= 1'b1;
                     hi_o          <= src_a_i;
                     lo_o          <= '1;
                     div_by_zero_o <= 1'b1;
                  end else if (accept_short) begin
                     state  <= FIX;
                     busy_o <= 1'b1;
                  end else begin
                     state  <= CALC;
                     busy_o <= 1'b1;
                  end
               end
            end
            CALC: begin
               if (annul_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  if (is_div_r) begin
                     a_r <= div_a_nx;
                  end else begin
                     acc_r <= mul_acc_nx;
                     a_r   <= mul_a_nx;
                     b_r   <= mul_b_nx;
                  end
                  cnt <= cnt - CW'(1);
                  if (calc_last)
                     state <= FIX;
               end
            end
            FIX: begin
               busy_o <= 1'b0;
               if (annul_i) begin
                  state <= IDLE;
               end else begin
                  state   <= DONE;
                  ready_o <= 1'b1;
                  if (is_div_r) begin
                     hi_o <= rem;
                     lo_o <= quo;
                  end else begin
                     hi_o <= prod[2*WIDTH-1:WIDTH];
                     lo_o <= prod[WIDTH-1:0];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed/scoreboard bench for muldiv_iter at WIDTH=32: results, latency, busy,
// divide-by-zero, annul and mid-operation reset behaviour.
module tb_muldiv_iter;
   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start_i;
   logic [1:0]    op_i;
   logic [W-1:0]  src_a_i;
   logic [W-1:0]  src_b_i;
   logic          annul_i;
   logic          busy_o;
   logic          ready_o;
   logic [W-1:0]  hi_o;
   logic [W-1:0]  lo_o;
   logic          div_by_zero_o;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           lat;
   } exp_t;

   exp_t         sb_q[$];
   int           n_vec = 0;
   int           n_mis = 0;
   logic [W-1:0] last_hi = '0;
   logic [W-1:0] last_lo = '0;
   logic         last_dbz = 1'b0;

   muldiv_iter #(.WIDTH(W)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .start_i       (start_i),
      .op_i          (op_i),
      .src_a_i       (src_a_i),
      .src_b_i       (src_b_i),
      .annul_i       (annul_i),
      .busy_o        (busy_o),
      .ready_o       (ready_o),
      .hi_o          (hi_o),
      .lo_o          (lo_o),
      .div_by_zero_o (div_by_zero_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t         e;
      logic [63:0]  p;
      longint       sa, sb, q, r;
      logic [W-1:0] bmag;
      int           msb;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      e.dbz = 1'b0;
      e.lat = W + 1;
      e.hi  = '0;
      e.lo  = '0;
      case (op)
         2'd0: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
         2'd1: begin p = {32'h0, a} * {32'h0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         default: begin
            if (b == '0) begin
               e.hi = a; e.lo = '1; e.dbz = 1'b1; e.lat = 1;
            end else if (op == 2'd2) begin
               q = sa / sb; r = sa % sb;
               e.lo = 32'(q); e.hi = 32'(r);
            end else begin
               e.lo = a / b; e.hi = a % b;
            end
         end
      endcase
`ifdef MULDIV_EARLY_OUT_EN
      if (!op[1]) begin
         bmag = (op == 2'd0 && b[W-1]) ? -b : b;
         msb  = 0;
         for (int i = 0; i < W; i++) if (bmag[i]) msb = i;
         e.lat = msb + 2;
      end
`endif
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      if (push) sb_q.push_back(model(op, a, b));
      @(negedge clk);
      start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
      @(posedge clk); #1;
      start_i = 1'b0; op_i = ~op; src_a_i = ~a; src_b_i = ~b;
   endtask

   // Called #1 after the accepting edge, i.e. in cycle 1 of the operation.
   task automatic wait_result(input bit disturb);
      exp_t e;
      int   cyc;
      e   = sb_q.pop_front();
      cyc = 1;
      while (!ready_o && cyc < 100) begin
         check("busy_during_op", busy_o, 1);
         @(negedge clk);
         if (disturb && cyc == 5) begin
            start_i = 1'b1; op_i = 2'b01; src_a_i = 32'd3; src_b_i = 32'd3;
         end
         @(posedge clk); #1;
         start_i = 1'b0;
         cyc++;
      end
      check("ready_seen", ready_o, 1);
      check("latency", cyc, e.lat);
      check("hi", hi_o, e.hi);
      check("lo", lo_o, e.lo);
      check("div_by_zero", div_by_zero_o, e.dbz);
      check("busy_at_ready", busy_o, 0);
      last_hi  = e.hi;
      last_lo  = e.lo;
      last_dbz = e.dbz;
      @(posedge clk); #1;
      check("ready_pulse_end", ready_o, 0);
      check("hi_held", hi_o, last_hi);
      check("lo_held", lo_o, last_lo);
      check("dbz_held", div_by_zero_o, last_dbz);
   endtask

   initial begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0; src_a_i = '0; src_b_i = '0;
      #12;
      check("rst_busy", busy_o, 0);
      check("rst_ready", ready_o, 0);
      check("rst_hi", hi_o, 0);
      check("rst_lo", lo_o, 0);
      check("rst_dbz", div_by_zero_o, 0);
      @(negedge clk) resetn = 1'b1;

      issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1); wait_result(0);
      issue(2'd0, 32'hFFFFFFFD, 32'd7, 1);        wait_result(0);
      issue(2'd2, 32'hFFFFFFF9, 32'd2, 1);        wait_result(0);
      issue(2'd3, 32'd7, 32'd2, 1);               wait_result(0);
      issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1); wait_result(0);
      issue(2'd3, 32'd5, 32'd0, 1);               wait_result(0);
      issue(2'd0, 32'h80000000, 32'h80000000, 1); wait_result(0);
      issue(2'd2, 32'd7, 32'hFFFFFFFE, 1);        wait_result(0);
      issue(2'd2, 32'hFFFFFFFB, 32'd0, 1);        wait_result(0);
      issue(2'd2, 32'd0, 32'd5, 1);               wait_result(0);
      issue(2'd0, 32'h7FFFFFFF, 32'h80000000, 1); wait_result(0);
      issue(2'd3, 32'hFFFFFFFF, 32'd1, 1);        wait_result(0);

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         issue(rop, ra, rb, 1); wait_result(0);
      end

      // A start while busy must not restart or replace the running divide.
      issue(2'd3, 32'd1000, 32'd3, 1); wait_result(1);

      // start with annul in IDLE is not accepted.
      @(negedge clk); start_i = 1'b1; annul_i = 1'b1; op_i = 2'd1; src_a_i = 32'd9; src_b_i = 32'd9;
      @(posedge clk); #1; start_i = 1'b0; annul_i = 1'b0;
      check("idle_annul_busy", busy_o, 0);
      @(posedge clk); #1;
      check("idle_annul_ready", ready_o, 0);
      check("idle_annul_lo", lo_o, last_lo);

      // Annul during CALC: busy drops next cycle, results untouched, no ready.
      issue(2'd2, 32'd100, 32'd7, 0);
      for (int c = 1; c < 10; c++) begin
         check("busy_before_annul", busy_o, 1);
         @(posedge clk); #1;
      end
      @(negedge clk); annul_i = 1'b1;
      @(posedge clk); #1; annul_i = 1'b0;
      check("annul_busy", busy_o, 0);
      for (int c = 0; c < 4; c++) begin
         check("annul_no_ready", ready_o, 0);
         check("annul_hi_kept", hi_o, last_hi);
         check("annul_lo_kept", lo_o, last_lo);
         @(posedge clk); #1;
      end

      // Asynchronous reset mid-operation clears every output at once.
      issue(2'd2, 32'd100, 32'd7, 0);
      for (int c = 1; c < 10; c++) @(posedge clk);
      @(negedge clk); resetn = 1'b0;
      #1;
      check("midrst_busy", busy_o, 0);
      check("midrst_ready", ready_o, 0);
      check("midrst_hi", hi_o, 0);
      check("midrst_lo", lo_o, 0);
      check("midrst_dbz", div_by_zero_o, 0);
      @(negedge clk); @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", busy_o, 0);
      last_hi = '0; last_lo = '0; last_dbz = 1'b0;

      issue(2'd1, 32'd12345, 32'd678, 1); wait_result(0);
      issue(2'd2, 32'hFFFFFF9C, 32'd7, 1); wait_result(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
